// File: rtl/fp_sched_pkg.sv
// Purpose : shared op encodings, default unit latencies and reservation slot type for the FP issue scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package fp_sched_pkg;

   typedef enum logic [1:0] {
      FP_OP_ADD = 2'd0,
      FP_OP_MUL = 2'd1,
      FP_OP_DIV = 2'd2,
      FP_OP_RSV = 2'd3
   } fp_op_e;

   localparam int FP_ADD_LAT_DEF = 2;
   localparam int FP_MUL_LAT_DEF = 4;
   localparam int FP_DIV_LAT_DEF = 8;

   // One write-port reservation: which register gets written, by which unit.
   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic [1:0] unit;
   } resv_slot_t;

endpackage

// File: rtl/fp_wb_slot_shifter.sv
// Purpose : DEPTH-deep reservation array for the shared FP write port; slot[0] is the current writeback.
// Latency : an entry inserted at index i reaches slot[0] i cycles after the insert edge.
// Backpressure: none; the caller must only insert into a slot that is free after the shift.
// Ports   : clk, rst_n; ins_en/ins_idx/ins_slot insert one reservation per cycle;
//           head = slot[0]; slot_vld = per-slot valid bits (for port-conflict lookahead).
module fp_wb_slot_shifter
   import fp_sched_pkg::*;
#(
   parameter int DEPTH = FP_DIV_LAT_DEF,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ins_en,
   input  logic [IW-1:0]    ins_idx,
   input  resv_slot_t       ins_slot,
   output resv_slot_t       head,
   output logic [DEPTH-1:0] slot_vld
);

   resv_slot_t slot [DEPTH];

   // Shift toward slot[0] every cycle; the insert is applied after the shift
   // so it lands in the position it will hold for the coming cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
      end else begin
         for (int k = 0; k < DEPTH - 1; k++) slot[k] <= slot[k+1];
         slot[DEPTH-1] <= '0;
         if (ins_en) slot[ins_idx] <= ins_slot;
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) slot_vld[k] = slot[k].valid;
   end

   assign head = slot[0];

   // An insert over a reservation that is still live after the shift would
   // mean two writebacks in one cycle.
   logic collide;
   always_comb begin
      collide = 1'b0;
      if (ins_en && (int'(ins_idx) < DEPTH - 1)) collide = slot_vld[ins_idx + 1'b1];
   end

   a_one_wb_per_cycle: assert property (@(posedge clk) disable iff (!rst_n) !collide);

endmodule

// File: rtl/fp_issue_scheduler.sv
// Purpose : FP scoreboard + issue scheduler for ADD/MUL/DIV sharing one FP register-file write port.
// Latency : stall/fp_issue combinational from ID; an op issued in cycle t writes back in t+L(op).
// Backpressure: stall on RAW/WAW/divider-busy/write-port conflict; id_hold blocks issue but not stall.
// Ports   : clk, rst_n; id_valid/id_op/id_fs/id_ft/id_use_ft/id_fd/id_hold from ID;
//           stall, fp_issue to the pipeline; wb_valid/wb_reg/wb_unit to the FP RF; div_busy, fp_idle status.
module fp_issue_scheduler
   import fp_sched_pkg::*;
#(
   parameter int ADD_LAT = FP_ADD_LAT_DEF,
   parameter int MUL_LAT = FP_MUL_LAT_DEF,
   parameter int DIV_LAT = FP_DIV_LAT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [1:0] id_op,
   input  logic [4:0] id_fs,
   input  logic [4:0] id_ft,
   input  logic       id_use_ft,
   input  logic [4:0] id_fd,
   input  logic       id_hold,
   output logic       stall,
   output logic       fp_issue,
   output logic       wb_valid,
   output logic [4:0] wb_reg,
   output logic [1:0] wb_unit,
   output logic       div_busy,
   output logic       fp_idle
);

   localparam int IW = $clog2(DIV_LAT);

   logic [31:0]        pend;
   logic [IW-1:0]      div_cnt;
   logic [IW-1:0]      ins_idx;
   logic [IW-1:0]      port_idx;
   logic               port_chk;
   logic [DIV_LAT-1:0] slot_vld;
   resv_slot_t         head;
   resv_slot_t         ins_slot;
   logic [31:0]        wb_oh;
   logic [31:0]        epend;
   logic               op_ok;
   logic               raw, waw, strct, port;

   // Reserved encoding behaves as if nothing were in ID.
   assign op_ok = id_valid & (id_op != FP_OP_RSV);

   // Insert position is L-1 (written after the shift); the conflict probe
   // looks at slot[L], which becomes slot[L-1] at the next edge. The divider
   // has L == DIV_LAT, beyond the array, so it never probes.
   always_comb begin
      ins_idx  = '0;
      port_idx = '0;
      port_chk = 1'b0;
      case (id_op)
         FP_OP_ADD: begin
            ins_idx  = IW'(ADD_LAT - 1);
            port_idx = IW'(ADD_LAT);
            port_chk = 1'b1;
         end
         FP_OP_MUL: begin
            ins_idx  = IW'(MUL_LAT - 1);
            port_idx = IW'(MUL_LAT);
            port_chk = 1'b1;
         end
         FP_OP_DIV: ins_idx = IW'(DIV_LAT - 1);
         default:   ;
      endcase
   end

   assign wb_valid = head.valid;
   assign wb_reg   = head.dst;
   assign wb_unit  = head.unit;

   // Write-first register file: this cycle's writeback already resolves its hazard.
   assign wb_oh = wb_valid ? (32'd1 << wb_reg) : 32'd0;
   assign epend = pend & ~wb_oh;

   assign raw      = epend[id_fs] | (id_use_ft & epend[id_ft]);
   assign waw      = epend[id_fd];
   assign strct    = (id_op == FP_OP_DIV) & div_busy;
   assign port     = port_chk & slot_vld[port_idx];
   assign stall    = op_ok & (raw | waw | strct | port);
   assign fp_issue = op_ok & ~stall & ~id_hold;

   assign ins_slot = '{valid: 1'b1, dst: id_fd, unit: id_op};

   fp_wb_slot_shifter #(
      .DEPTH (DIV_LAT),
      .IW    (IW)
   ) u_slots (
      .clk      (clk),
      .rst_n    (rst_n),
      .ins_en   (fp_issue),
      .ins_idx  (ins_idx),
      .ins_slot (ins_slot),
      .head     (head),
      .slot_vld (slot_vld)
   );

   // Set after clear so a same-register issue during writeback keeps the bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend <= (pend & ~wb_oh) | (fp_issue ? (32'd1 << id_fd) : 32'd0);
      end
   end

   // Counts down DIV_LAT-1 cycles so a new divide can issue on the cycle the
   // previous one writes back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (fp_issue && (id_op == FP_OP_DIV)) begin
         div_cnt <= IW'(DIV_LAT - 1);
      end else if (div_cnt != '0) begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   assign div_busy = (div_cnt != '0);
   assign fp_idle  = ~|pend & ~|slot_vld;

endmodule

// File: tb/tb_fp_issue_scheduler.sv
module tb_fp_issue_scheduler;

   localparam int ADD_L = 2;
   localparam int MUL_L = 4;
   localparam int DIV_L = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [1:0] id_op = 2'd0;
   logic [4:0] id_fs = 5'd0;
   logic [4:0] id_ft = 5'd0;
   logic       id_use_ft = 1'b0;
   logic [4:0] id_fd = 5'd0;
   logic       id_hold = 1'b0;
   logic       stall, fp_issue, wb_valid, div_busy, fp_idle;
   logic [4:0] wb_reg;
   logic [1:0] wb_unit;

   always #5 clk = ~clk;

   fp_issue_scheduler #(.ADD_LAT(ADD_L), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_fs(id_fs),
      .id_ft(id_ft), .id_use_ft(id_use_ft), .id_fd(id_fd), .id_hold(id_hold),
      .stall(stall), .fp_issue(fp_issue), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_unit(wb_unit), .div_busy(div_busy), .fp_idle(fp_idle)
   );

   // Reference model: list of in-flight operations with their absolute writeback cycle.
   typedef struct {
      int wb;
      int rd;
      int unit;
   } op_t;

   op_t fl[$];
   int  now = 0;
   int  checks = 0;
   int  errors = 0;
   bit  last_issue;

   function automatic int lat_of(int op);
      case (op)
         0:       return ADD_L;
         1:       return MUL_L;
         default: return DIV_L;
      endcase
   endfunction

   function automatic bit pending(int r);
      foreach (fl[i]) if (fl[i].wb > now && fl[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit div_inflight();
      foreach (fl[i]) if (fl[i].wb > now && fl[i].unit == 2) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit wb_taken(int cyc);
      foreach (fl[i]) if (fl[i].wb == cyc) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, now);
      end
   endtask

   // Check all outputs for the current cycle at the falling edge, then advance the model.
   task automatic step();
      bit v, e_stall, e_issue, e_wbv;
      int L, e_reg, e_unit;
      @(negedge clk);
      v = id_valid && (id_op != 2'd3);
      L = lat_of(int'(id_op));
      e_stall = v && (pending(int'(id_fs)) || (id_use_ft && pending(int'(id_ft))) ||
                      pending(int'(id_fd)) || (id_op == 2'd2 && div_inflight()) ||
                      (id_op != 2'd2 && wb_taken(now + L)));
      e_issue = v && !e_stall && !id_hold;
      e_wbv = 1'b0; e_reg = 0; e_unit = 0;
      foreach (fl[i]) if (fl[i].wb == now) begin
         e_wbv = 1'b1; e_reg = fl[i].rd; e_unit = fl[i].unit;
      end
      chk("stall", stall, e_stall);
      chk("fp_issue", fp_issue, e_issue);
      chk("wb_valid", wb_valid, e_wbv);
      chk("wb_reg", wb_reg, e_reg);
      chk("wb_unit", wb_unit, e_unit);
      chk("div_busy", div_busy, div_inflight());
      chk("fp_idle", fp_idle, fl.size() == 0);
      last_issue = e_issue;
      @(posedge clk);
      if (e_issue && rst_n) fl.push_back('{wb: now + L, rd: int'(id_fd), unit: int'(id_op)});
      now++;
      for (int i = fl.size() - 1; i >= 0; i--) if (fl[i].wb < now) fl.delete(i);
      #1;
   endtask

   task automatic present(input int op, input int fd, input int fs, input int ft, input bit hold);
      id_valid = 1'b1; id_op = 2'(op); id_fd = 5'(fd); id_fs = 5'(fs); id_ft = 5'(ft);
      id_use_ft = 1'b1; id_hold = hold;
   endtask

   task automatic idle(input int n);
      id_valid = 1'b0; id_hold = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Steps until the presented op issues; n = number of cycles it was held back.
   task automatic wait_issue(input int maxc, output int n);
      n = 0;
      forever begin
         step();
         if (last_issue) break;
         n++;
         if (n > maxc) begin
            checks++; errors++;
            $error("FAIL issue_timeout observed=%0d expected<=%0d", n, maxc);
            break;
         end
      end
      id_valid = 1'b0;
   endtask

   int n;

   initial begin
      // Reset held for three clocks: every output at its reset value.
      repeat (3) step();
      @(negedge clk); rst_n = 1'b1; @(posedge clk); now++; #1;

      // Basic ADD f2 <- f4,f6: writeback of f2 two cycles later.
      present(0, 2, 4, 6, 0); step();
      chk("add_issued", last_issue, 1);
      idle(1);
      chk("add_wb_reg_now", {27'd0, wb_reg}, 2);
      chk("add_wb_vld_now", wb_valid, 1);
      idle(2);

      // RAW: ADD reading f8 waits for MUL f8, issuing on the writeback cycle.
      present(1, 8, 1, 1, 0); step();
      present(0, 10, 8, 1, 0); wait_issue(20, n);
      chk("raw_stall_cycles", n, 3);
      idle(3);

      // Write-port conflict: MUL f3 then ADD f5 two cycles later.
      present(1, 3, 0, 0, 0); step();
      idle(1);
      present(0, 5, 11, 12, 0); wait_issue(20, n);
      chk("port_stall_cycles", n, 1);
      idle(5);

      // Divider structural hazard: back-to-back DIVs eight cycles apart.
      present(2, 7, 13, 14, 0); step();
      present(2, 9, 13, 14, 0); wait_issue(20, n);
      chk("div_stall_cycles", n, 7);
      idle(DIV_L + 1);

      // WAW with external hold, then set-wins reissue on writeback cycle.
      present(0, 2, 0, 0, 0); step();
      present(0, 2, 0, 0, 1); step(); step();
      id_hold = 1'b0; wait_issue(5, n);
      chk("waw_hold_release", n, 0);
      idle(1);
      present(0, 2, 0, 0, 0); wait_issue(5, n);
      chk("set_wins_issue", n, 0);
      chk("set_wins_not_idle", fp_idle, 0);
      idle(3);

      // Async reset mid-flight: DIV f7 and ADD f11 in progress.
      present(2, 7, 0, 0, 0); step();
      present(0, 11, 0, 0, 0); step();
      idle(1);
      chk("pre_rst_wb", wb_valid, 1);
      rst_n = 1'b0; #1;
      chk("rst_wb_drop", wb_valid, 0);
      chk("rst_div_busy", div_busy, 0);
      chk("rst_idle", fp_idle, 1);
      fl.delete();
      idle(2);
      rst_n = 1'b1;
      idle(DIV_L + 4);

      // Randomized traffic over a small register window to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         id_valid  = ($urandom_range(9) < 7);
         id_op     = 2'($urandom_range(3));
         id_fs     = 5'($urandom_range(7));
         id_ft     = 5'($urandom_range(7));
         id_fd     = 5'($urandom_range(7));
         id_use_ft = 1'($urandom_range(1));
         id_hold   = ($urandom_range(4) == 0);
         step();
      end
      idle(DIV_L + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
